// File: rtl/alu_sequencer.sv
//==============================================================================
// Module      : alu_sequencer
// Description : Request/response controller driving a combinational ALU;
//               adds a two-pass add-with-carry-in composite operation.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [3:0]           req_op_i,
    input  logic                 req_cin_i,
    input  logic [BUS_WIDTH-1:0] req_a_i,
    input  logic [BUS_WIDTH-1:0] req_b_i,
    output logic [3:0]           alu_opcode_o,
    output logic [BUS_WIDTH-1:0] alu_num_0_o,
    output logic [BUS_WIDTH-1:0] alu_num_1_o,
    input  logic [BUS_WIDTH-1:0] alu_num_out_i,
    input  logic                 alu_over_flag_i,
    input  logic                 alu_zero_flag_i,
    input  logic                 alu_greater_flag_i,
    input  logic                 alu_equal_flag_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [BUS_WIDTH-1:0] rsp_data_o,
    output logic                 rsp_over_o,
    output logic                 rsp_zero_o,
    output logic                 rsp_greater_o,
    output logic                 rsp_equal_o
);

    localparam logic [3:0] C_OP_NUL = 4'b0000;
    localparam logic [3:0] C_OP_ADD = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CARRY = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           opcode_q, opcode_d;
    logic [BUS_WIDTH-1:0] num0_q, num0_d;
    logic [BUS_WIDTH-1:0] num1_q, num1_d;
    logic                 cin_q, cin_d;
    logic                 valid_q, valid_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 over_q, over_d;
    logic                 zero_q, zero_d;
    logic                 greater_q, greater_d;
    logic                 equal_q, equal_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            opcode_q  <= C_OP_NUL;
            num0_q    <= '0;
            num1_q    <= '0;
            cin_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            over_q    <= 1'b0;
            zero_q    <= 1'b0;
            greater_q <= 1'b0;
            equal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            num0_q    <= num0_d;
            num1_q    <= num1_d;
            cin_q     <= cin_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            over_q    <= over_d;
            zero_q    <= zero_d;
            greater_q <= greater_d;
            equal_q   <= equal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        num0_d    = num0_q;
        num1_d    = num1_q;
        cin_d     = cin_q;
        valid_d   = valid_q;
        data_d    = data_q;
        over_d    = over_q;
        zero_d    = zero_q;
        greater_d = greater_q;
        equal_d   = equal_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    opcode_d = req_op_i;
                    num0_d   = req_a_i;
                    num1_d   = req_b_i;
                    cin_d    = req_cin_i;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                data_d    = alu_num_out_i;
                over_d    = alu_over_flag_i;
                zero_d    = alu_zero_flag_i;
                greater_d = alu_greater_flag_i;
                equal_d   = alu_equal_flag_i;
                if (opcode_q == C_OP_ADD && cin_q) begin
                    num0_d  = alu_num_out_i;
                    num1_d  = BUS_WIDTH'(1);
                    state_d = CARRY;
                end else begin
                    state_d = RESP;
                end
            end
            CARRY: begin
                // greater/equal keep the first-pass comparison of the original operands
                data_d  = alu_num_out_i;
                over_d  = over_q | alu_over_flag_i;
                zero_d  = alu_zero_flag_i;
                state_d = RESP;
            end
            RESP: begin
                // valid is launched one cycle after the result registers settle
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (rsp_ready_i) begin
                    valid_d  = 1'b0;
                    opcode_d = C_OP_NUL;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign alu_opcode_o  = opcode_q;
    assign alu_num_0_o   = num0_q;
    assign alu_num_1_o   = num1_q;
    assign rsp_valid_o   = valid_q;
    assign rsp_data_o    = data_q;
    assign rsp_over_o    = over_q;
    assign rsp_zero_o    = zero_q;
    assign rsp_greater_o = greater_q;
    assign rsp_equal_o   = equal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//==============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with a behavioural ALU.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_alu_sequencer;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         over;
        logic         zero;
        logic         greater;
        logic         equal;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = 4'h0;
    logic         req_cin = 1'b0;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_num_0, alu_num_1, alu_num_out;
    logic         alu_over, alu_zero, alu_greater, alu_equal;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_data;
    logic         rsp_over, rsp_zero, rsp_greater, rsp_equal;

    int n_checks = 0;
    int n_fail   = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_sequencer #(.BUS_WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_cin_i(req_cin), .req_a_i(req_a), .req_b_i(req_b),
        .alu_opcode_o(alu_opcode), .alu_num_0_o(alu_num_0), .alu_num_1_o(alu_num_1),
        .alu_num_out_i(alu_num_out),
        .alu_over_flag_i(alu_over), .alu_zero_flag_i(alu_zero),
        .alu_greater_flag_i(alu_greater), .alu_equal_flag_i(alu_equal),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_over_o(rsp_over), .rsp_zero_o(rsp_zero),
        .rsp_greater_o(rsp_greater), .rsp_equal_o(rsp_equal)
    );

    // Behavioural combinational ALU
    always_comb begin
        logic [W:0] s;
        s = '0;
        alu_over = 1'b0;
        case (alu_opcode)
            4'b0001: begin
                s = {1'b0, alu_num_0} + {1'b0, alu_num_1};
                alu_num_out = s[W-1:0];
                alu_over = s[W];
            end
            4'b0010: begin
                alu_num_out = (alu_num_0 >= alu_num_1) ? alu_num_0 - alu_num_1 : alu_num_1 - alu_num_0;
                alu_over = (alu_num_0 < alu_num_1);
            end
            4'b0011: alu_num_out = alu_num_0 ^ alu_num_1;
            4'b0100: alu_num_out = alu_num_0 & alu_num_1;
            4'b1000: alu_num_out = alu_num_0 | alu_num_1;
            default: alu_num_out = '0;
        endcase
        alu_zero    = (alu_num_out == '0);
        alu_greater = (alu_num_0 > alu_num_1);
        alu_equal   = (alu_num_0 == alu_num_1);
    end

    function automatic rsp_t expect_of(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin);
        rsp_t r;
        logic [W+1:0] full;
        full = '0;
        r.over = 1'b0;
        case (op)
            4'b0001: begin
                full = {2'b00, a} + {2'b00, b} + {{(W+1){1'b0}}, cin};
                r.data = full[W-1:0];
                r.over = full[W];
            end
            4'b0010: begin
                r.data = (a >= b) ? a - b : b - a;
                r.over = (a < b);
            end
            4'b0011: r.data = a ^ b;
            4'b0100: r.data = a & b;
            4'b1000: r.data = a | b;
            default: r.data = '0;
        endcase
        r.zero    = (r.data == '0);
        r.greater = (a > b);
        r.equal   = (a == b);
        return r;
    endfunction

    function automatic rsp_t observed();
        rsp_t r;
        r.data = rsp_data; r.over = rsp_over; r.zero = rsp_zero;
        r.greater = rsp_greater; r.equal = rsp_equal;
        return r;
    endfunction

    // Drives one command (ready expected), pushes its expectation, waits for and
    // consumes the response; returns latency and ALU operands one edge after EXEC.
    task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, b, input logic cin,
                           output int lat, output logic [W-1:0] n0, n1, output rsp_t obs);
        req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(expect_of(op, a, b, cin));
        #1 req_valid = 1'b0;
        lat = 0; n0 = '0; n1 = '0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                n0 = alu_num_0;
                n1 = alu_num_1;
            end
        end
        obs = observed();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (req_ready !== 1'b1 || alu_opcode !== 4'h0 || alu_num_0 !== '0 || alu_num_1 !== '0 ||
            rsp_valid !== 1'b0 || observed() !== '0) begin
            n_fail++;
            $display("FAIL reset: ready=%b op=%h n0=%h n1=%h valid=%b rsp=%h required ready=1 rest 0",
                     req_ready, alu_opcode, alu_num_0, alu_num_1, rsp_valid, observed());
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_simple(input string name, input logic [3:0] op, input logic [W-1:0] a, b,
                               input logic cin, input int exp_lat);
        int lat; logic [W-1:0] n0, n1; rsp_t obs, e;
        run_cmd(op, a, b, cin, lat, n0, n1, obs);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL %s data: got %h/o%b z%b g%b e%b required %h/o%b z%b g%b e%b", name,
                     obs.data, obs.over, obs.zero, obs.greater, obs.equal,
                     e.data, e.over, e.zero, e.greater, e.equal);
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_add_carry();
        int lat; logic [W-1:0] n0, n1; rsp_t obs, e;
        run_cmd(4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b1, lat, n0, n1, obs);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (n0 !== 32'hFFFF_FFFF || n1 !== 32'h1) begin
            n_fail++;
            $display("FAIL carry_pass2: got n0=%h n1=%h required n0=ffffffff n1=00000001", n0, n1);
        end
        n_checks++;
        if (obs !== e || e !== {32'h0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL carry_rsp: got %h required %h", obs, e);
        end
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL carry_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_backpressure();
        int lat; rsp_t held, e;
        req_op = 4'b0100; req_a = 32'hF0F0_1234; req_b = 32'h0FF0_FF00; req_cin = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(expect_of(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0));
        #1;
        // second command stays presented throughout
        req_op = 4'b1000; req_a = 32'h1234_0000; req_b = 32'h0000_5678;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        held = observed();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (held !== e || lat !== 2) begin
            n_fail++;
            $display("FAIL bp_first: got %h lat %0d required %h lat 2", held, lat, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (observed() !== held || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got rsp=%h valid=%b ready=%b required rsp=%h valid=1 ready=0",
                         i, observed(), rsp_valid, req_ready, held);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_after_hs: got ready=%b valid=%b required ready=1 valid=0", req_ready, rsp_valid);
        end
        @(posedge clk);
        exp_q.push_back(expect_of(4'b1000, 32'h1234_0000, 32'h0000_5678, 1'b0));
        #1 req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0 || alu_opcode !== 4'b1000 || alu_num_0 !== 32'h1234_0000) begin
            n_fail++;
            $display("FAIL bp_second_accept: got ready=%b op=%h n0=%h required ready=0 op=8 n0=12340000",
                     req_ready, alu_opcode, alu_num_0);
        end
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (observed() !== e || lat !== 2) begin
            n_fail++;
            $display("FAIL bp_second: got %h lat %0d required %h lat 2", observed(), lat, e);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        req_op = 4'b0001; req_a = 32'h10; req_b = 32'h20; req_cin = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(expect_of(4'b0001, 32'h10, 32'h20, 1'b1));
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || alu_opcode !== 4'h0 || rsp_valid !== 1'b0 || alu_num_0 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got ready=%b op=%h valid=%b n0=%h required ready=1 op=0 valid=0 n0=0",
                     req_ready, alu_opcode, rsp_valid, alu_num_0);
        end
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_reset_no_rsp: got rsp_valid=1 required 0");
        end
        test_simple("post_reset_add", 4'b0001, 32'd1, 32'd1, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_simple("add_5_7", 4'b0001, 32'd5, 32'd7, 1'b0, 2);
        test_add_carry();
        test_simple("sub_3_10", 4'b0010, 32'd3, 32'd10, 1'b1, 2);
        test_simple("xor_eq", 4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 2);
        test_simple("unlisted_0111", 4'b0111, 32'h1234, 32'h99, 1'b1, 2);
        test_simple("nul", 4'b0000, 32'h55, 32'h55, 1'b0, 2);
        test_simple("add_wrap_cin0", 4'b0001, 32'hFFFF_FFFF, 32'h2, 1'b0, 2);
        test_simple("add_cin1", 4'b0001, 32'd100, 32'd200, 1'b1, 3);
        test_backpressure();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side controller for the combinational ALU. It accepts arithmetic/logic commands over a valid/ready request channel and drives the ALU operand and opcode inputs from registers. It captures the ALU result and flags, and returns them over a valid/ready response channel. It adds one composite operation, add-with-carry-in, which it executes as two sequential ALU passes.

## Interface
- BUS_WIDTH, 32, operand/result width; must match the attached ALU.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted on the edge where req_valid & req_ready.
- req_op  in  4  opcode, same encoding as the ALU: NUL 0000, ADD 0001, SUB 0010, XOR 0011, AND 0100, OR 1000.
- req_cin  in  1  carry-in; used only when req_op = ADD.
- req_a, req_b  in  BUS_WIDTH  operands.
- alu_opcode  out  4  registered opcode to the ALU.
- alu_num_0, alu_num_1  out  BUS_WIDTH  registered operands to the ALU.
- alu_num_out  in  BUS_WIDTH  ALU result.
- alu_over_flag, alu_zero_flag, alu_greater_flag, alu_equal_flag  in  1  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed on the edge where rsp_valid & rsp_ready.
- rsp_data  out  BUS_WIDTH  result.
- rsp_over, rsp_zero, rsp_greater, rsp_equal  out  1  result flags.

## Operation
- States: IDLE, EXEC, CARRY, RESP.
- **IDLE**
  - req_ready = 1; it is 0 in all other states.
  - On request handshake: load alu_opcode = req_op, alu_num_0 = req_a, alu_num_1 = req_b, latch req_cin, go to EXEC.
- **EXEC** (ALU sees the registered operands)
  - Capture alu_num_out into rsp_data and all four flags into the rsp_* flag registers.
  - If the opcode is ADD and the latched cin = 1:
    - load alu_num_0 = alu_num_out, alu_num_1 = 1, keep alu_opcode = ADD;
    - go to CARRY.
  - Otherwise go to RESP.
- **CARRY**
  - rsp_data = alu_num_out.
  - rsp_over = first-pass over OR second-pass over.
  - rsp_zero = second-pass zero.
  - rsp_greater and rsp_equal keep their first-pass values, which compare the original a and b.
  - Go to RESP.
- **RESP**
  - rsp_valid = 1.
  - On response handshake: go to IDLE and restore alu_opcode to NUL.
  - alu_num_0 and alu_num_1 hold their last values.
- **Result semantics**
  - SUB returns |a−b| with over = 1 iff a < b.
  - Unlisted opcodes are forwarded unchanged; the ALU returns 0, so zero = 1 and over = 0.
  - NUL returns 0 with zero = 1.
  - req_cin is ignored for every opcode except ADD.
- Carry width rule: a + b + cin is computed modulo 2^BUS_WIDTH. rsp_over = 1 iff the true sum ≥ 2^BUS_WIDTH. The two passes cannot both overflow.

## Timing
- **Reset values** (asynchronous, while rst_n = 0)
  - State IDLE, so req_ready = 1.
  - alu_opcode = NUL; alu_num_0 and alu_num_1 = 0.
  - rsp_valid = 0; rsp_data = 0; all rsp flags = 0.
- **Latency**
  - Request handshake at edge k; EXEC occupies cycle k+1.
  - Single pass: rsp_valid rises after edge k+2.
  - ADD with cin = 1: rsp_valid rises after edge k+3.
- **Throughput**: one command outstanding. The earliest next accept is the edge after the response handshake, since IDLE is re-entered on that edge.
- **Response channel**: rsp_data and the rsp flags are stable while rsp_valid = 1 and rsp_ready = 0. rsp_ready asserted before rsp_valid has no effect.
- **Request channel**: req_valid while not in IDLE is ignored, not queued. Request inputs are sampled only on the handshake edge.
- **Reset mid-operation**: the command in flight is dropped and no response is issued. All outputs return to their reset values.

## Test plan
- ADD a=5, b=7, cin=0 → rsp_data=12, over=0, zero=0, greater=0, equal=0; rsp_valid exactly 2 cycles after accept.
- ADD a=0xFFFFFFFF, b=0, cin=1 → second pass drives alu_num_0=0xFFFFFFFF, alu_num_1=1. Response: rsp_data=0, over=1, zero=1, greater=1, equal=0; latency 3.
- SUB a=3, b=10 → rsp_data=7, over=1, greater=0, equal=0.
- XOR a=b=0xA5A5A5A5 → rsp_data=0, zero=1, equal=1, over=0. Also issue opcode 0111 → rsp_data=0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 and a second command present → response fields constant, req_ready=0, second command accepted only on the edge after the response handshake.
- Assert rst_n=0 during EXEC of an ADD with cin=1 → rsp_valid never rises, alu_opcode=0, req_ready=1 immediately. A fresh ADD 1+1 afterwards → rsp_data=2.
